// File: rtl/cpu_pkg.sv
// Types and constants shared by the CPU front end.
// iq_entry_t is the fetch-to-decode instruction queue payload.
package cpu_pkg;

    localparam logic [31:0] RESET_PC = 32'hbfc0_0000;

    typedef struct packed {
        logic        adel;
        logic [31:0] pc;
        logic [31:0] instr;
    } iq_entry_t;

endpackage

// File: rtl/if_inst_queue.sv
// Instruction queue between fetch and decode. It absorbs icache-miss stalls in fetch
// and decode stalls, and a flush empties it in one cycle by moving rd_ptr to wr_ptr.
module if_inst_queue
    import cpu_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             flush,
    input  logic             push_valid,
    input  logic [31:0]      push_pc,
    input  logic [31:0]      push_instr,
    input  logic             push_adel,
    output logic             push_ready,
    output logic             pop_valid,
    input  logic             pop_ready,
    output logic [31:0]      pop_pc,
    output logic [31:0]      pop_instr,
    output logic             pop_adel,
    output logic [PTR_W:0]   count,
    output logic             fetch_stall
);

    localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

    logic [PTR_W:0]   wr_ptr_reg, wr_ptr_next;
    logic [PTR_W:0]   rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0] wr_idx, rd_idx;
    logic             empty, full;
    logic             push_fire, pop_fire;
    iq_entry_t        mem_reg [DEPTH];
    iq_entry_t        head;

    assign wr_idx = wr_ptr_reg[PTR_W-1:0];
    assign rd_idx = rd_ptr_reg[PTR_W-1:0];

    // The extra wrap bit distinguishes full from empty when the indices match.
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_idx == rd_idx) && (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]);

    assign push_ready  = ~full | pop_ready;
    assign fetch_stall = ~push_ready;
    assign pop_valid   = ~empty;
    assign count       = wr_ptr_reg - rd_ptr_reg;

    assign push_fire = push_valid & push_ready & ~flush;
    assign pop_fire  = pop_valid & pop_ready & ~flush;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        if (flush) begin
            rd_ptr_next = wr_ptr_reg;
        end else begin
            if (push_fire) wr_ptr_next = wr_ptr_reg + PTR_ONE;
            if (pop_fire)  rd_ptr_next = rd_ptr_reg + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
        end
    end

    // Payload storage needs no reset; the pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (aresetn && push_fire) begin
            mem_reg[wr_idx] <= '{adel: push_adel, pc: push_pc, instr: push_instr};
        end
    end

    assign head      = mem_reg[rd_idx];
    assign pop_pc    = head.pc;
    assign pop_instr = head.instr;
    assign pop_adel  = head.adel;

endmodule
